// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of requester handshake, FIFO status and FIFO write port used by fifo_wr_arbiter.
// The master side drives requests and FIFO flags; the slave side is the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    localparam int OW = $clog2(NREQ);

    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic               fifo_full;
    logic               fifo_halffull;
    logic [NREQ-1:0]    gnt;
    logic               wr_en;
    logic [DW-1:0]      data_out;
    logic [OW-1:0]      owner;
    logic               busy;

    modport master (
        output req, req_data, fifo_full, fifo_halffull,
        input  gnt, wr_en, data_out, owner, busy
    );

    modport slave (
        input  req, req_data, fifo_full, fifo_halffull,
        output gnt, wr_en, data_out, owner, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that merges NREQ word streams into one FIFO write port,
// granting bursts of up to BURST words and stalling on FIFO full.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int BURST = 4
) (
    input logic               clk,
    input logic               rst,
    fifo_wr_arbiter_if.slave  bus
);
    localparam int OW = $clog2(NREQ);
    localparam int CW = $clog2(BURST + 1);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] last_q, last_d;
    logic [OW-1:0] pick;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] limit_q, limit_d;
    logic          accept;

    // Scan downward so the nearest set request after last_q wins; OW-bit wrap gives mod NREQ.
    always_comb begin
        pick = last_q;
        for (int k = NREQ; k >= 1; k--) begin
            if (bus.req[last_q + OW'(k)]) begin
                pick = last_q + OW'(k);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        limit_d      = limit_q;
        accept       = 1'b0;
        bus.gnt      = '0;
        bus.wr_en    = 1'b0;
        bus.data_out = '0;
        bus.busy     = 1'b0;
        bus.owner    = owner_q;

        case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    owner_d = pick;
                    cnt_d   = '0;
                    limit_d = bus.fifo_halffull ? CW'(1) : CW'(BURST);
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                bus.busy     = 1'b1;
                bus.data_out = bus.req_data[int'(owner_q) * DW +: DW];
                accept       = bus.req[owner_q] & ~bus.fifo_full;
                if (!bus.req[owner_q]) begin
                    state_d = S_IDLE;
                    last_d  = owner_q;
                end else if (accept) begin
                    cnt_d = cnt_q + CW'(1);
                    if ((cnt_q + CW'(1)) == limit_q) begin
                        state_d = S_IDLE;
                        last_d  = owner_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        bus.wr_en = accept;
        if (accept) begin
            bus.gnt[owner_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            last_q  <= OW'(NREQ - 1);
            cnt_q   <= '0;
            limit_q <= CW'(BURST);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            limit_q <= limit_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed bench for fifo_wr_arbiter against a queue-free
// "remaining beats" model of the arbitration rules.
module tb_fifo_wr_arbiter;
    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int BURST = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST(BURST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int nvec = 0;
    int nbad = 0;

    // Model: in a burst or not, who owns it, who owned the previous one, beats still allowed.
    int m_busy, m_owner, m_last, m_left;

    logic       exp_wr, exp_busy;
    logic [3:0] exp_gnt;
    logic [1:0] exp_owner;
    logic [7:0] exp_data;

    function automatic void model_eval();
        exp_owner = 2'(m_owner);
        exp_busy  = (m_busy != 0);
        exp_wr    = 1'b0;
        exp_gnt   = 4'b0;
        exp_data  = 8'h00;
        if (m_busy != 0) begin
            exp_data = bus.req_data[m_owner * DW +: DW];
            if (bus.req[m_owner] && !bus.fifo_full) begin
                exp_wr  = 1'b1;
                exp_gnt = 4'(1 << m_owner);
            end
        end
    endfunction

    function automatic void model_next();
        bit found;
        if (rst) begin
            m_busy = 0; m_owner = 0; m_last = NREQ - 1; m_left = 0;
        end else if (m_busy != 0) begin
            if (!bus.req[m_owner]) begin
                m_busy = 0; m_last = m_owner;
            end else if (!bus.fifo_full) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_busy = 0; m_last = m_owner;
                end
            end
        end else if (bus.req != 0) begin
            found = 0;
            for (int j = 1; j <= NREQ; j++) begin
                if (!found && bus.req[(m_last + j) % NREQ]) begin
                    m_owner = (m_last + j) % NREQ;
                    found   = 1;
                end
            end
            m_left = bus.fifo_halffull ? 1 : BURST;
            m_busy = 1;
        end
    endfunction

    task automatic drive(input logic r, input logic [3:0] rq, input logic [31:0] rd,
                         input logic f, input logic hf);
        rst               = r;
        bus.req           = rq;
        bus.req_data      = rd;
        bus.fifo_full     = f;
        bus.fifo_halffull = hf;
        #1;
        model_eval();
    endtask

    task automatic tick();
        model_next();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1'b1, 4'b0, 32'h0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_reset();
        drive(1'b1, 4'b1111, $urandom, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'($urandom), $urandom, 1'b0, 1'b0);
        nvec++;
        if ({bus.wr_en, bus.gnt, bus.busy, bus.owner, bus.data_out} !== 16'h0) begin
            nbad++;
            $display("FAIL reset_state got wr/gnt/busy/own/dat=%b/%b/%b/%0d/%h want all zero",
                     bus.wr_en, bus.gnt, bus.busy, bus.owner, bus.data_out);
        end
        tick();
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, 4'b1111, $urandom, 1'b0, 1'b0);
            if (c == 1) begin
                nvec++;
                if (bus.gnt !== 4'b0001 || bus.owner !== 2'd0) begin
                    nbad++;
                    $display("FAIL reset_first_grant got gnt=%b own=%0d want gnt=0001 own=0",
                             bus.gnt, bus.owner);
                end
            end
            tick();
        end
    endtask

    task automatic test_all_req();
        int writes = 0;
        int k = 0;
        int first[4];
        logic prev_wr = 1'b0;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            drive(1'b0, 4'b1111, $urandom, 1'b0, 1'b0);
            nvec++;
            if ({bus.wr_en, bus.gnt, bus.busy, bus.owner} !== {exp_wr, exp_gnt, exp_busy, exp_owner}
                || (exp_busy && bus.data_out !== exp_data)) begin
                nbad++;
                $display("FAIL all_req c=%0d got wr/gnt/busy/own/dat=%b/%b/%b/%0d/%h want %b/%b/%b/%0d/%h",
                         c, bus.wr_en, bus.gnt, bus.busy, bus.owner, bus.data_out,
                         exp_wr, exp_gnt, exp_busy, exp_owner, exp_data);
            end
            if (bus.wr_en === 1'b1) begin
                writes++;
                if (!prev_wr && k < 4) begin
                    first[k] = int'(bus.owner);
                    k++;
                end
            end
            prev_wr = bus.wr_en;
            tick();
        end
        nvec++;
        if (writes != 16 || k != 4) begin
            nbad++;
            $display("FAIL all_req_count got writes=%0d bursts=%0d want writes=16 bursts=4", writes, k);
        end
        for (int i = 0; i < k; i++) begin
            nvec++;
            if (first[i] != i) begin
                nbad++;
                $display("FAIL all_req_order burst=%0d got owner=%0d want %0d", i, first[i], i);
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] v = 8'h01;
        logic [9:0] wmask = '0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, (v <= 8'h06) ? 4'b0100 : 4'b0000, {8'h00, v, 16'h0000}, 1'b0, 1'b0);
            nvec++;
            if ({bus.wr_en, bus.gnt, bus.busy, bus.owner} !== {exp_wr, exp_gnt, exp_busy, exp_owner}) begin
                nbad++;
                $display("FAIL single c=%0d got wr/gnt/busy/own=%b/%b/%b/%0d want %b/%b/%b/%0d",
                         c, bus.wr_en, bus.gnt, bus.busy, bus.owner, exp_wr, exp_gnt, exp_busy, exp_owner);
            end
            if (bus.wr_en === 1'b1) begin
                wmask[c] = 1'b1;
                nvec++;
                if (bus.data_out !== v || bus.gnt !== 4'b0100) begin
                    nbad++;
                    $display("FAIL single_word c=%0d got dat=%h gnt=%b want dat=%h gnt=0100",
                             c, bus.data_out, bus.gnt, v);
                end
                v++;
            end
            tick();
        end
        nvec++;
        if (wmask !== 10'b0011011110 || v !== 8'h07) begin
            nbad++;
            $display("FAIL single_pattern got mask=%b next=%h want mask=0011011110 next=07", wmask, v);
        end
    endtask

    task automatic test_full_stall();
        int post = 0;
        logic f;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            f = (c >= 3 && c <= 7);
            drive(1'b0, 4'b0010, $urandom, f, 1'b0);
            nvec++;
            if ({bus.wr_en, bus.gnt, bus.busy, bus.owner} !== {exp_wr, exp_gnt, exp_busy, exp_owner}
                || (exp_busy && bus.data_out !== exp_data)) begin
                nbad++;
                $display("FAIL stall c=%0d got wr/gnt/busy/own=%b/%b/%b/%0d want %b/%b/%b/%0d",
                         c, bus.wr_en, bus.gnt, bus.busy, bus.owner, exp_wr, exp_gnt, exp_busy, exp_owner);
            end
            if (f) begin
                nvec++;
                if (bus.wr_en !== 1'b0 || bus.gnt !== 4'b0 || bus.busy !== 1'b1 || bus.owner !== 2'd1) begin
                    nbad++;
                    $display("FAIL stall_hold c=%0d got wr/gnt/busy/own=%b/%b/%b/%0d want 0/0000/1/1",
                             c, bus.wr_en, bus.gnt, bus.busy, bus.owner);
                end
            end
            if (c >= 8 && c <= 10 && bus.wr_en === 1'b1) post++;
            tick();
        end
        nvec++;
        if (post != 2) begin
            nbad++;
            $display("FAIL stall_resume got words=%0d want 2", post);
        end
    endtask

    task automatic test_halffull();
        logic [3:0] seq[4];
        int k = 0;
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b1000; seq[3] = 4'b0001;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, 4'b1011, $urandom, 1'b0, 1'b1);
            nvec++;
            if (bus.wr_en !== 1'(c % 2) || bus.gnt !== ((c % 2 == 1) ? seq[c / 2] : 4'b0)) begin
                nbad++;
                $display("FAIL halffull c=%0d got wr=%b gnt=%b want wr=%0d gnt=%b",
                         c, bus.wr_en, bus.gnt, c % 2, (c % 2 == 1) ? seq[c / 2] : 4'b0);
            end
            if (bus.wr_en === 1'b1) k++;
            tick();
        end
        nvec++;
        if (k != 4) begin
            nbad++;
            $display("FAIL halffull_count got %0d want 4", k);
        end
    endtask

    task automatic test_drop();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, (c < 2) ? 4'b1000 : 4'b0001, $urandom, 1'b0, 1'b0);
            nvec++;
            if ({bus.wr_en, bus.gnt, bus.busy, bus.owner} !== {exp_wr, exp_gnt, exp_busy, exp_owner}) begin
                nbad++;
                $display("FAIL drop c=%0d got wr/gnt/busy/own=%b/%b/%b/%0d want %b/%b/%b/%0d",
                         c, bus.wr_en, bus.gnt, bus.busy, bus.owner, exp_wr, exp_gnt, exp_busy, exp_owner);
            end
            if (c == 1 || c == 3 || c == 4) begin
                nvec++;
                if ((c == 1 && bus.gnt !== 4'b1000) || (c == 3 && bus.busy !== 1'b0)
                    || (c == 4 && bus.gnt !== 4'b0001)) begin
                    nbad++;
                    $display("FAIL drop_step c=%0d got gnt=%b busy=%b want c1:1000 c3:idle c4:0001",
                             c, bus.gnt, bus.busy);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(c == 3, (c < 4) ? 4'b1111 : 4'b0110, $urandom, 1'b0, 1'b0);
            if (c == 3) begin
                nvec++;
                if (bus.wr_en !== 1'b1 || bus.gnt !== 4'b0001) begin
                    nbad++;
                    $display("FAIL rstmid_beat3 got wr=%b gnt=%b want 1/0001", bus.wr_en, bus.gnt);
                end
            end
            if (c == 4) begin
                nvec++;
                if ({bus.wr_en, bus.gnt, bus.busy, bus.owner, bus.data_out} !== 16'h0) begin
                    nbad++;
                    $display("FAIL rstmid_after got wr/gnt/busy/own/dat=%b/%b/%b/%0d/%h want all zero",
                             bus.wr_en, bus.gnt, bus.busy, bus.owner, bus.data_out);
                end
            end
            if (c == 5) begin
                nvec++;
                if (bus.gnt !== 4'b0010 || bus.owner !== 2'd1) begin
                    nbad++;
                    $display("FAIL rstmid_regrant got gnt=%b own=%0d want 0010/1", bus.gnt, bus.owner);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic r;
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            r = ($urandom_range(0, 99) == 0);
            drive(r, 4'($urandom), $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
            nvec++;
            if ({bus.wr_en, bus.gnt, bus.busy, bus.owner} !== {exp_wr, exp_gnt, exp_busy, exp_owner}
                || (exp_busy && bus.data_out !== exp_data)
                || (bus.wr_en === 1'b1 && bus.fifo_full === 1'b1)) begin
                nbad++;
                $display("FAIL random c=%0d got wr/gnt/busy/own/dat=%b/%b/%b/%0d/%h want %b/%b/%b/%0d/%h",
                         c, bus.wr_en, bus.gnt, bus.busy, bus.owner, bus.data_out,
                         exp_wr, exp_gnt, exp_busy, exp_owner, exp_data);
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.req = '0;
        bus.req_data = '0;
        bus.fifo_full = 1'b0;
        bus.fifo_halffull = 1'b0;
        m_busy = 0; m_owner = 0; m_last = NREQ - 1; m_left = 0;
        @(negedge clk);
        test_reset();
        test_all_req();
        test_single();
        test_full_stall();
        test_halffull();
        test_drop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
